// File: rtl/k_fifo2_ctrl.sv
// Occupancy/pointer controller for a 2-entry dual-port RAM, forming a 2-deep valid/ready FIFO.
// Optional saturating input-stall counter enabled by defining K_FIFO2_STALL_CNT_EN.
module k_fifo2_ctrl #(
   parameter int unsigned STALL_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   ram_wen,
   output logic                   ram_waddr,
   output logic                   ram_raddr,
   output logic [1:0]             count,
   output logic                   full,
   output logic                   empty
`ifdef K_FIFO2_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_FULL  = 2'b10
   } state_t;

   state_t state;
   logic   wptr;
   logic   rptr;
   logic   push;
   logic   pop;

   always_comb begin
      in_ready  = rst_n & (state != S_FULL);
      out_valid = rst_n & (state != S_EMPTY);
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready & ~flush;
      ram_wen   = push;
      ram_waddr = wptr;
      ram_raddr = rptr;
      count     = 2'd0;
      unique case (state)
         S_ONE:   count = 2'd1;
         S_FULL:  count = 2'd2;
         default: count = 2'd0;
      endcase
      full  = (state == S_FULL);
      empty = (state == S_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state <= S_EMPTY;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         case (state)
            S_EMPTY: if (push) state <= S_ONE;
            S_ONE: begin
               if (push && !pop)      state <= S_FULL;
               else if (pop && !push) state <= S_EMPTY;
            end
            S_FULL:  if (pop) state <= S_ONE;
            default: begin
               // Unreachable code: also realign pointers so the invariants hold again.
               state <= S_EMPTY;
               wptr  <= 1'b0;
               rptr  <= 1'b0;
            end
         endcase
      end
   end

`ifdef K_FIFO2_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_k_fifo2_ctrl.sv
// Scoreboard bench for k_fifo2_ctrl with a behavioural 2-entry RAM attached.
// Stall-counter scenario runs only when K_FIFO2_STALL_CNT_EN is defined.
module tb_k_fifo2_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic       ram_wen;
   logic       ram_waddr;
   logic       ram_raddr;
   logic [1:0] count;
   logic       full;
   logic       empty;
`ifdef K_FIFO2_STALL_CNT_EN
   logic [1:0] stall_cnt;
`endif

   logic [7:0] din;
   logic [7:0] mem [2];
   logic [7:0] q;
   logic [7:0] sb [$];
   logic [7:0] exp_q;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_wen) mem[ram_waddr] <= din;
   assign q = mem[ram_raddr];

   k_fifo2_ctrl #(.STALL_CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ram_wen   (ram_wen),
      .ram_waddr (ram_waddr),
      .ram_raddr (ram_raddr),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef K_FIFO2_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // Apply inputs shortly after an edge; outputs are sampled 1ns later.
   task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [7:0] d);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      din       = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 8'h55);
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({in_ready, out_valid, ram_wen} !== 3'b000) $display("FAIL reset_hold: rdy/vld/wen=%b required 000", {in_ready, out_valid, ram_wen});
         else passed++;
         tick();
      end
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if ({count, empty, full, ram_wen, ram_waddr, ram_raddr} !== 7'b00_1_0_0_0_0)
         $display("FAIL reset_state: cnt=%0d empty=%b full=%b wen=%b wa=%b ra=%b required 0 1 0 0 0 0",
                  count, empty, full, ram_wen, ram_waddr, ram_raddr);
      else passed++;
   endtask

   task automatic test_push_pop();
      drive(1'b1, 1'b0, 1'b0, 8'hA1);
      total++;
      if ({ram_wen, ram_waddr} !== 2'b10) $display("FAIL push_a1: wen/waddr=%b required 10", {ram_wen, ram_waddr});
      else passed++;
      sb.push_back(8'hA1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 8'hB2);
      total++;
      if ({ram_wen, ram_waddr} !== 2'b11) $display("FAIL push_b2: wen/waddr=%b required 11", {ram_wen, ram_waddr});
      else passed++;
      sb.push_back(8'hB2);
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if ({count, full, in_ready} !== 4'b10_1_0) $display("FAIL full_state: cnt=%0d full=%b rdy=%b required 2 1 0", count, full, in_ready);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         exp_q = sb.pop_front();
         total++;
         if (out_valid !== 1'b1 || ram_raddr !== i[0] || q !== exp_q)
            $display("FAIL drain_%0d: vld=%b raddr=%b q=%h required 1 %b %h", i, out_valid, ram_raddr, q, i[0], exp_q);
         else passed++;
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (empty !== 1'b1) $display("FAIL drained_empty: empty=%b required 1", empty);
      else passed++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(i));
         total++;
         if (in_ready !== 1'b1 || ram_wen !== 1'b1 || ram_waddr !== i[0])
            $display("FAIL stream_push_%0d: rdy=%b wen=%b waddr=%b required 1 1 %b", i, in_ready, ram_wen, ram_waddr, i[0]);
         else passed++;
         if (i > 0) begin
            exp_q = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || q !== exp_q)
               $display("FAIL stream_pop_%0d: vld=%b q=%h required 1 %h", i, out_valid, q, exp_q);
            else passed++;
         end
         sb.push_back(8'(i));
         tick();
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         total++;
         if (count !== 2'd1 || full !== 1'b0) $display("FAIL stream_cnt_%0d: cnt=%0d full=%b required 1 0", i, count, full);
         else passed++;
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      exp_q = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || q !== exp_q) $display("FAIL stream_last: vld=%b q=%h required 1 %h", out_valid, q, exp_q);
      else passed++;
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (empty !== 1'b1 || ram_waddr !== ram_raddr) $display("FAIL stream_end: empty=%b wa=%b ra=%b required 1 equal", empty, ram_waddr, ram_raddr);
      else passed++;
   endtask

   task automatic fill_two(input logic [7:0] a, input logic [7:0] b);
      drive(1'b1, 1'b0, 1'b0, a);
      sb.push_back(a);
      tick();
      drive(1'b1, 1'b0, 1'b0, b);
      sb.push_back(b);
      tick();
   endtask

   task automatic test_flush();
      fill_two(8'hC3, 8'hD4);
      drive(1'b1, 1'b1, 1'b1, 8'hEE);
      total++;
      if (ram_wen !== 1'b0) $display("FAIL flush_wen: wen=%b required 0", ram_wen);
      else passed++;
      sb.delete();
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if ({count, out_valid, ram_waddr, ram_raddr, empty} !== 6'b00_0_0_0_1)
         $display("FAIL flush_state: cnt=%0d vld=%b wa=%b ra=%b empty=%b required 0 0 0 0 1",
                  count, out_valid, ram_waddr, ram_raddr, empty);
      else passed++;
   endtask

   task automatic test_full_pop();
      fill_two(8'hE5, 8'hF6);
      drive(1'b1, 1'b1, 1'b0, 8'h77);
      exp_q = sb.pop_front();
      total++;
      if (ram_wen !== 1'b0 || in_ready !== 1'b0 || q !== exp_q)
         $display("FAIL full_pop: wen=%b rdy=%b q=%h required 0 0 %h", ram_wen, in_ready, q, exp_q);
      else passed++;
      tick();
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      exp_q = sb.pop_front();
      total++;
      if (count !== 2'd1 || q !== exp_q) $display("FAIL full_pop_after: cnt=%0d q=%h required 1 %h", count, q, exp_q);
      else passed++;
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (empty !== 1'b1) $display("FAIL full_pop_empty: empty=%b required 1", empty);
      else passed++;
   endtask

`ifdef K_FIFO2_STALL_CNT_EN
   task automatic test_stall_cnt();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      tick();
      fill_two(8'h11, 8'h22);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'h33);
         tick();
         total++;
         if (stall_cnt !== exp_seq[i]) $display("FAIL stall_%0d: stall_cnt=%0d required %0d", i, stall_cnt, exp_seq[i]);
         else passed++;
      end
      drive(1'b1, 1'b0, 1'b1, 8'h33);
      sb.delete();
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (stall_cnt !== 2'd0) $display("FAIL stall_flush: stall_cnt=%0d required 0", stall_cnt);
      else passed++;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      test_reset();
      test_push_pop();
      test_back_to_back();
      test_flush();
      test_full_pop();
`ifdef K_FIFO2_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/k_fifo2_ctrl.md
Name: k_fifo2_ctrl

Overview:
Sequencing controller for the team's 2-entry dual-port RAM primitive (async read `q = mem[raddr]`, write on posedge clk when wen). It tracks occupancy, owns the 1-bit read/write pointers and drives the RAM's wen/waddr/raddr. It presents valid/ready handshakes on the producer and consumer sides, so the controller plus the RAM form a 2-deep FIFO. It sits between pipeline stages as a skid/elastic buffer.

Parameters:
STALL_CNT_W, 8, width of the optional saturating stall counter (only used with K_FIFO2_STALL_CNT_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of FIFO contents; priority over push/pop.
- in_valid  in  1  producer has a data word on the RAM d input.
- in_ready  out  1  controller accepts the word this cycle.
- out_valid  out  1  RAM q holds a valid head word.
- out_ready  in  1  consumer takes the head word this cycle.
- ram_wen  out  1  to RAM wen.
- ram_waddr  out  1  to RAM waddr.
- ram_raddr  out  1  to RAM raddr.
- count  out  2  occupancy, 0..2.
- full  out  1  count==2.
- empty  out  1  count==0.
- stall_cnt  out  STALL_CNT_W  only with K_FIFO2_STALL_CNT_EN.

Behaviour:
- State machine (registered), 3 states:
  - S_EMPTY (count=0), S_ONE (count=1), S_FULL (count=2).
  - Encoding is free; the fourth code is unreachable and must recover to S_EMPTY on the next edge.
- Registers: state, wptr (1b), rptr (1b).
- Combinational outputs:
  - in_ready = rst_n & (state != S_FULL); no write while full, even if popping the same cycle.
  - out_valid = rst_n & (state != S_EMPTY).
  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
  - ram_wen = push; ram_waddr = wptr; ram_raddr = rptr.
- Output data latency:
  - A word written at edge N is visible on q, with out_valid=1, in cycle N+1. Zero-cycle fall-through is not supported.
  - The head word is combinationally available while out_valid=1.
- Pointer update on posedge:
  - push toggles wptr (mod-2 wrap).
  - pop toggles rptr.
  - Both may toggle in the same cycle.
- Transitions (evaluated in priority order):
  - ~rst_n -> S_EMPTY, wptr=0, rptr=0.
  - flush -> S_EMPTY, wptr=0, rptr=0; RAM contents are left stale and never read.
  - S_EMPTY: push -> S_ONE; pop is impossible.
  - S_ONE: push & ~pop -> S_FULL; pop & ~push -> S_EMPTY; push & pop -> S_ONE.
    - Simultaneous push and pop hit different slots: waddr != raddr.
  - S_FULL: pop -> S_ONE; push is impossible.
- count/full/empty are decoded from state.
- Reset values, during and after the reset edge:
  - in_ready=0 and out_valid=0 while rst_n=0.
  - After the reset edge: count=0, empty=1, full=0, ram_wen=0, ram_waddr=0, ram_raddr=0.
- Reset or flush asserted mid-transfer: any in-flight push/pop that cycle is discarded, and no RAM write occurs.
- Invariants:
  - count==2 implies wptr==rptr.
  - count==0 implies wptr==rptr.
  - count==1 implies wptr!=rptr.

Optional Feature:
Macro: K_FIFO2_STALL_CNT_EN
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with in_valid=1 and in_ready=0 (rst_n=1, flush=0).
  - Saturates at all-ones.
  - Cleared to 0 by rst_n=0 or flush=1.
- Not defined:
  - stall_cnt port and its register are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while in_valid=1 -> in_ready=0, out_valid=0, ram_wen=0; after release count=0, empty=1, raddr=waddr=0.
2. Push 0xA1 then 0xB2 with out_ready=0 -> wen pulses with waddr 0 then 1; count=2, full=1, in_ready=0. Then out_ready=1 for 2 cycles -> q reads 0xA1 (raddr=0) then 0xB2 (raddr=1); then empty=1.
3. Steady stream, in_valid=out_ready=1 for 10 cycles with data 0..9 -> count holds at 1 after the first cycle; output order 0..9; pointers wrap every 2 pushes; no full.
4. Fill to 2 entries, then assert push, pop and flush in the same cycle -> next cycle count=0, wptr=rptr=0, ram_wen=0 during the flush cycle, out_valid=0.
5. Full FIFO with in_valid=1 and out_ready=1 in one cycle -> only pop occurs; count=1; ram_wen=0 that cycle.
6. (K_FIFO2_STALL_CNT_EN, STALL_CNT_W=2) Hold full with in_valid=1 for 5 cycles -> stall_cnt sequence 1,2,3,3,3; flush -> 0.
